// File: rtl/fsm_seqdet.sv
// Serial pattern detector: one-hot matcher with a registered match pulse and a saturating match counter.
// The transition table is built at elaboration from PATTERN, so any pattern and overlap mode needs no hand coding.
module fsm_seqdet #(
  parameter int unsigned  N       = 4,
  parameter logic [N-1:0] PATTERN = 4'b1011,
  parameter bit           OVERLAP = 1'b1,
  parameter int unsigned  CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in,
  input  logic             cnt_clr,
  output logic             out,
  output logic [N-1:0]     state,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Pattern bit i in arrival order; PATTERN[N-1] arrives first.
  function automatic logic pat_bit(input int i);
    return 1'(PATTERN >> (int'(N) - 1 - i));
  endfunction

  // Longest pattern prefix that is a suffix of (first k pattern bits, then b).
  function automatic int next_len(input int k, input logic b);
    logic ok;
    logic sb;
    for (int l = k + 1; l >= 1; l--) begin
      if (l <= int'(N)) begin
        ok = 1'b1;
        for (int j = 0; j < l; j++) begin
          sb = (k + 1 - l + j == k) ? b : pat_bit(k + 1 - l + j);
          if (sb != pat_bit(j)) ok = 1'b0;
        end
        if (ok) return l;
      end
    end
    return 0;
  endfunction

  // Longest proper border of the pattern: where an overlapping search resumes.
  function automatic int border_len();
    logic ok;
    for (int l = int'(N) - 1; l >= 1; l--) begin
      ok = 1'b1;
      for (int j = 0; j < l; j++) begin
        if (pat_bit(j) != pat_bit(int'(N) - l + j)) ok = 1'b0;
      end
      if (ok) return l;
    end
    return 0;
  endfunction

  localparam int RESTART = OVERLAP ? border_len() : 0;

  function automatic logic [N-1:0] trans(input int k, input logic b);
    int l;
    l = next_len(k, b);
    return N'(1) << ((l == int'(N)) ? RESTART : l);
  endfunction

  logic [N-1:0]        match_c;
  logic [N-1:0]        adv_c;
  logic [N-1:0][N-1:0] term_c;
  logic [N-1:0]        state_d;
  logic                out_d;
  logic [CNT_W-1:0]    cnt_d;

  for (genvar k = 0; k < int'(N); k++) begin : g_state
    localparam logic [N-1:0] T0 = trans(k, 1'b0);
    localparam logic [N-1:0] T1 = trans(k, 1'b1);
    localparam logic         M0 = (next_len(k, 1'b0) == int'(N));
    localparam logic         M1 = (next_len(k, 1'b1) == int'(N));
    assign match_c[k] = state[k] & (in ? M1 : M0);
    for (genvar j = 0; j < int'(N); j++) begin : g_term
      assign term_c[j][k] = state[k] & (in ? T1[j] : T0[j]);
    end
  end

  for (genvar j = 0; j < int'(N); j++) begin : g_adv
    assign adv_c[j] = |term_c[j];
  end

  // Next-state, pulse and counter; an illegal state vector always recovers to S0.
  always_comb begin
    state_d = state;
    out_d   = 1'b0;
    cnt_d   = cnt;
    if (!$onehot(state)) begin
      state_d = N'(1);
    end else if (en) begin
      state_d = adv_c;
      out_d   = |match_c;
    end
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (out_d && (cnt != CNT_MAX)) begin
      cnt_d = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= N'(1);
      out   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      out   <= out_d;
      cnt   <= cnt_d;
    end
  end

endmodule
